// File: rtl/fifo_pin_sequencer.sv
// rtl/fifo_pin_sequencer.sv - pin synchroniser, request arbiter and status tracker for the FIFO core
module fifo_pin_sequencer #(
    parameter int DEPTH       = 16,
    parameter int AE_THRESH   = 2,
    parameter int AF_THRESH   = 14,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_pin,
    input  logic                         rd_pin,
    input  logic                         clr_pin,
    output logic                         push,
    output logic                         pop,
    output logic                         rd_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [7:0]                   status,
    output logic [7:0]                   status_oe
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int SET_W  = $clog2(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] wr_sync, rd_sync, clr_sync;
    logic                   wr_s, rd_s, clr_s;
    logic                   wr_prev, rd_prev, clr_prev;
    logic                   wr_edge, rd_edge, clr_edge;
    logic [SET_W-1:0]       settle;
    logic                   wr_pend, rd_pend;
    logic                   empty, full, almost_empty, almost_full;
    logic                   overflow, underflow;

    logic                   push_n, pop_n, wr_take, rd_take, ovf_set, unf_set;
    logic [CNT_W-1:0]       cnt_n;

    assign wr_s  = wr_sync[SYNC_STAGES-1];
    assign rd_s  = rd_sync[SYNC_STAGES-1];
    assign clr_s = clr_sync[SYNC_STAGES-1];

    // Grant decision on the pending flags; the grant itself is registered below.
    always_comb begin
        push_n  = 1'b0;
        pop_n   = 1'b0;
        wr_take = 1'b0;
        rd_take = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (wr_pend && rd_pend) begin
            push_n  = 1'b1;
            wr_take = 1'b1;
            // When empty the read waits one cycle for the write it pairs with.
            if (!empty) begin
                pop_n   = 1'b1;
                rd_take = 1'b1;
            end
        end else if (wr_pend) begin
            wr_take = 1'b1;
            if (!full) push_n  = 1'b1;
            else       ovf_set = 1'b1;
        end else if (rd_pend) begin
            rd_take = 1'b1;
            if (!empty) pop_n   = 1'b1;
            else        unf_set = 1'b1;
        end
    end

    always_comb begin
        cnt_n = count;
        if (push_n && !pop_n)      cnt_n = count + CNT_W'(1);
        else if (pop_n && !push_n) cnt_n = count - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sync      <= '0;
            rd_sync      <= '0;
            clr_sync     <= '0;
            wr_prev      <= 1'b1;
            rd_prev      <= 1'b1;
            clr_prev     <= 1'b1;
            wr_edge      <= 1'b0;
            rd_edge      <= 1'b0;
            clr_edge     <= 1'b0;
            settle       <= '0;
            wr_pend      <= 1'b0;
            rd_pend      <= 1'b0;
            push         <= 1'b0;
            pop          <= 1'b0;
            rd_valid     <= 1'b0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_sync  <= {wr_sync[SYNC_STAGES-2:0], wr_pin};
            rd_sync  <= {rd_sync[SYNC_STAGES-2:0], rd_pin};
            clr_sync <= {clr_sync[SYNC_STAGES-2:0], clr_pin};

            // Hold the previous values high until the chains carry real pin levels,
            // so a pin held high through reset never looks like a fresh edge.
            if (settle < SET_W'(SYNC_STAGES)) begin
                settle   <= settle + SET_W'(1);
                wr_edge  <= 1'b0;
                rd_edge  <= 1'b0;
                clr_edge <= 1'b0;
            end else begin
                wr_prev  <= wr_s;
                rd_prev  <= rd_s;
                clr_prev <= clr_s;
                wr_edge  <= wr_s & ~wr_prev;
                rd_edge  <= rd_s & ~rd_prev;
                clr_edge <= clr_s & ~clr_prev;
            end

            wr_pend <= (wr_pend & ~wr_take) | wr_edge;
            rd_pend <= (rd_pend & ~rd_take) | rd_edge;

            push     <= push_n;
            pop      <= pop_n;
            rd_valid <= pop;

            count        <= cnt_n;
            empty        <= (cnt_n == CNT_W'(0));
            full         <= (cnt_n == CNT_W'(DEPTH));
            almost_empty <= (cnt_n <= CNT_W'(AE_THRESH));
            almost_full  <= (cnt_n >= CNT_W'(AF_THRESH));

            overflow  <= ovf_set | (overflow  & ~clr_edge);
            underflow <= unf_set | (underflow & ~clr_edge);
        end
    end

    assign status    = {rd_s, wr_s, almost_full, almost_empty, overflow, underflow, full, empty};
    assign status_oe = 8'hFF;

endmodule

// File: tb/tb_fifo_pin_sequencer.sv
// tb/tb_fifo_pin_sequencer.sv - directed self-checking bench for fifo_pin_sequencer
module tb_fifo_pin_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_pin = 1'b0;
    logic       rd_pin = 1'b0;
    logic       clr_pin = 1'b0;
    logic       push, pop, rd_valid;
    logic [4:0] count;
    logic [7:0] status, status_oe;

    int n_cmp = 0;
    int n_bad = 0;
    int push_cnt = 0;
    int pop_cnt = 0;
    int rv_cnt = 0;
    int p0, q0, r0;

    fifo_pin_sequencer #(
        .DEPTH(16), .AE_THRESH(2), .AF_THRESH(14), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .wr_pin(wr_pin), .rd_pin(rd_pin), .clr_pin(clr_pin),
        .push(push), .pop(pop), .rd_valid(rd_valid), .count(count),
        .status(status), .status_oe(status_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (push === 1'b1)     push_cnt++;
        if (pop === 1'b1)      pop_cnt++;
        if (rd_valid === 1'b1) rv_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // which: 0 = write, 1 = read, 2 = clear; a full request has been serviced on return
    task automatic pulse(input int which);
        if (which == 0) wr_pin = 1'b1;
        else if (which == 1) rd_pin = 1'b1;
        else clr_pin = 1'b1;
        step(3);
        wr_pin = 1'b0;
        rd_pin = 1'b0;
        clr_pin = 1'b0;
        step(3);
    endtask

    initial begin
        // reset state
        rst = 1'b1;
        step(2);
        check("rst_status", 32'(status), 32'h11);
        check("rst_count", 32'(count), 0);
        check("rst_push", 32'(push), 0);
        check("rst_pop", 32'(pop), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_oe", 32'(status_oe), 32'hFF);
        rst = 1'b0;
        step(3);

        // single held write: one push at latency 4
        p0 = push_cnt;
        wr_pin = 1'b1;
        step(4);
        check("lat_push_early", 32'(push), 0);
        step(1);
        check("lat_push", 32'(push), 1);
        check("lat_count", 32'(count), 1);
        check("lat_empty", 32'(status[0]), 0);
        check("lat_ae", 32'(status[4]), 1);
        check("lat_wr_s", 32'(status[6]), 1);
        step(5);
        wr_pin = 1'b0;
        step(3);
        check("held_one_push", 32'(push_cnt - p0), 1);

        // fill to full, checking threshold boundaries
        for (int i = 2; i <= 16; i++) begin
            pulse(0);
            check("fill_count", 32'(count), 32'(i));
            if (i == 2)  check("ae_at_2", 32'(status[4]), 1);
            if (i == 3)  check("ae_at_3", 32'(status[4]), 0);
            if (i == 13) check("af_at_13", 32'(status[5]), 0);
            if (i == 14) check("af_at_14", 32'(status[5]), 1);
            if (i == 15) check("full_at_15", 32'(status[1]), 0);
            if (i == 16) check("full_at_16", 32'(status[1]), 1);
        end
        p0 = push_cnt;
        pulse(0);
        check("ovf_no_push", 32'(push_cnt - p0), 0);
        check("ovf_set", 32'(status[3]), 1);
        check("ovf_count", 32'(count), 16);
        pulse(2);
        check("ovf_clr", 32'(status[3]), 0);
        check("clr_count", 32'(count), 16);
        check("clr_full", 32'(status[1]), 1);

        // drain
        q0 = pop_cnt;
        r0 = rv_cnt;
        for (int i = 0; i < 16; i++) pulse(1);
        check("drain_pops", 32'(pop_cnt - q0), 16);
        check("drain_rv", 32'(rv_cnt - r0), 16);
        check("drain_count", 32'(count), 0);
        check("drain_empty", 32'(status[0]), 1);

        // underflow
        q0 = pop_cnt;
        pulse(1);
        check("unf_no_pop", 32'(pop_cnt - q0), 0);
        check("unf_set", 32'(status[2]), 1);
        check("unf_count", 32'(count), 0);
        pulse(0);
        check("unf_wr_count", 32'(count), 1);
        check("unf_sticky", 32'(status[2]), 1);
        pulse(1);
        check("unf_rd_count", 32'(count), 0);
        pulse(2);
        check("unf_clr_status", 32'(status), 32'h11);

        // simultaneous requests at empty: push then pop
        wr_pin = 1'b1;
        rd_pin = 1'b1;
        step(4);
        check("both_e_idle_push", 32'(push), 0);
        check("both_e_idle_pop", 32'(pop), 0);
        step(1);
        check("both_e_push", 32'(push), 1);
        check("both_e_pop0", 32'(pop), 0);
        check("both_e_count1", 32'(count), 1);
        step(1);
        check("both_e_push0", 32'(push), 0);
        check("both_e_pop", 32'(pop), 1);
        check("both_e_count0", 32'(count), 0);
        step(1);
        check("both_e_rv", 32'(rd_valid), 1);
        wr_pin = 1'b0;
        rd_pin = 1'b0;
        step(3);
        check("both_e_unf", 32'(status[2]), 0);
        check("both_e_final", 32'(count), 0);

        // simultaneous requests at full
        for (int i = 0; i < 16; i++) pulse(0);
        check("refill_count", 32'(count), 16);
        wr_pin = 1'b1;
        rd_pin = 1'b1;
        step(5);
        check("both_f_push", 32'(push), 1);
        check("both_f_pop", 32'(pop), 1);
        check("both_f_count", 32'(count), 16);
        step(1);
        check("both_f_rv", 32'(rd_valid), 1);
        check("both_f_push0", 32'(push), 0);
        check("both_f_ovf", 32'(status[3]), 0);
        wr_pin = 1'b0;
        rd_pin = 1'b0;
        step(3);
        check("both_f_final", 32'(count), 16);

        // reset with a write pending and the pin held high
        wr_pin = 1'b1;
        step(4);
        p0 = push_cnt;
        rst = 1'b1;
        step(1);
        check("mid_rst_status", 32'(status), 32'h11);
        check("mid_rst_push", 32'(push), 0);
        step(1);
        rst = 1'b0;
        step(10);
        check("post_rst_pushes", 32'(push_cnt - p0), 0);
        check("post_rst_count", 32'(count), 0);
        check("post_rst_low", 32'(status[5:0]), 32'h11);
        check("post_rst_wr_s", 32'(status[6]), 1);
        wr_pin = 1'b0;
        step(3);
        check("post_rst_status", 32'(status), 32'h11);
        check("post_rst_pushes2", 32'(push_cnt - p0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
